uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL take parameter PARITY_MODE, default 1, meaning 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL take parameter STOP_BITS, default 1, meaning stop bits per transmitted frame, legal values 1 or 2.
REQ-004 The block SHALL take parameter CLKS_PER_BIT, default 16, meaning clk cycles per bit; it must be a multiple of 16 and at least 16.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge and no derived clocks exist.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: transmit word offered.
REQ-008 The block SHALL have port tx_data, input, DATA_W bits: transmit word.
REQ-009 The block SHALL have port tx_ready, output, 1 bit: transmitter can accept a word.
REQ-010 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-011 The block SHALL have port tx_out, output, 1 bit: serial line out, idle high.
REQ-012 The block SHALL have port rx_in, input, 1 bit: serial line in, asynchronous to clk.
REQ-013 The block SHALL have port loopback, input, 1 bit: 1 = receiver input is tx_out and the external rx_in is ignored.
REQ-014 The block SHALL have port rx_data, output, DATA_W bits: last received word.
REQ-015 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a frame completes.
REQ-016 The block SHALL have port parity_error, output, 1 bit: last frame parity mismatch; constant 0 when PARITY_MODE is 0.
REQ-017 The block SHALL have port stop_error, output, 1 bit: last frame stop bit sampled low.

Function
REQ-018 The tick generator SHALL pulse os_tick once every CLKS_PER_BIT/16 clocks, free-running from reset; one bit period is 16 os_ticks.
REQ-019 TX SHALL accept a word when tx_valid and tx_ready are both high in the same cycle; tx_ready = TX state is IDLE.
REQ-020 TX SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE is 0.
REQ-021 The start bit (0) SHALL appear on tx_out on the os_tick following acceptance; each bit lasts 16 os_ticks.
REQ-022 TX SHALL send data bits LSB first, followed by the parity bit, followed by STOP_BITS high bits.
REQ-023 The even parity bit SHALL be the XOR of the data bits; the odd parity bit SHALL be its inverse.
REQ-024 tx_busy SHALL be high from the cycle after acceptance until TX returns to IDLE at the end of the last stop bit.
REQ-025 tx_valid while tx_ready is low SHALL be ignored, and no word is queued.
REQ-026 RX SHALL pass its selected input through a 2-flop synchroniser before use.
REQ-027 RX SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-028 RX in IDLE SHALL wait for a low sample and then move to START.
REQ-029 In START, RX SHALL re-check the line at os_tick 8; if the line is high it returns to IDLE (glitch reject) and raises no flags.
REQ-030 After a valid START, RX SHALL sample each following bit at mid-bit, every 16 os_ticks.
REQ-031 RX SHALL check exactly one stop bit regardless of STOP_BITS.
REQ-032 At the stop-bit sample, RX SHALL update rx_data, parity_error and stop_error, pulse rx_valid for one clk, and return to IDLE.
REQ-033 rx_data, parity_error and stop_error SHALL hold their values until the next frame completes.
REQ-034 If stop_error is set, RX SHALL wait for the line to return high before leaving IDLE to look for a new start bit.
REQ-035 A change of loopback while TX or RX is not in IDLE produces undefined frame content; the block SHALL NOT hang and SHALL be back in IDLE within 2 frame times.

Reset
REQ-036 While rst is low at a clk edge, both state machines SHALL go to IDLE and the tick counter SHALL clear.
REQ-037 Under reset, outputs SHALL be: tx_out = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, parity_error = 0, stop_error = 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no rx_valid pulse, and tx_out SHALL be high on the next edge.

Structure
REQ-039 Package uart_pkg SHALL hold the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD and the TX and RX state enums.
REQ-040 One sub-module, uart_tick_gen (parameter CLKS_PER_BIT, output os_tick), SHALL generate the tick; the TX and RX state machines SHALL live in uart_core.

Verification
REQ-041 Loopback, defaults, tx_data 0xA5 -> tx_out bits 0,1,0,1,0,0,1,0,1,0,1; rx_valid after about 176 clk; rx_data 0xA5; both error flags 0.
REQ-042 Back-to-back words 0x00 then 0xFF with tx_valid held high -> tx_ready low for the whole frame; both words received in order; no word dropped or duplicated.
REQ-043 External rx_in frame 0x3C with parity bit 1 (even mode) -> rx_valid = 1, rx_data 0x3C, parity_error = 1, stop_error = 0.
REQ-044 External rx_in frame 0x81 with stop bit low -> stop_error = 1; a valid frame following after the line returns high is received cleanly.
REQ-045 A 4-clk low glitch on rx_in -> no rx_valid and all flags unchanged.
REQ-046 rst pulsed low in mid data bit, in loopback -> tx_out high next edge, no rx_valid, tx_ready = 1; the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and the parity helper.
// Both uart_core and its testbench-visible behaviour depend on these names.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one os_tick every CLKS_PER_BIT/16 clocks.
// With CLKS_PER_BIT = 16 the tick is high on every clock.
module uart_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  output logic os_tick
);

  localparam int DIV = CLKS_PER_BIT / 16;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign os_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_core.sv
// UART transmitter and 16x-oversampling receiver sharing one tick generator.
// tx_out is registered and updated on os_tick, so every bit lags its TX state by one tick.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_out,
  input  logic              rx_in,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_error,
  output logic              stop_error
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic os_tick;

  uart_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .os_tick (os_tick)
  );

  tx_state_e         tx_state_q, tx_state_d;
  logic [3:0]        tx_tcnt_q, tx_tcnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_cur;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_out_d   = tx_out_q;
    tx_cur     = 1'b1;

    case (tx_state_q)
      TX_START:  tx_cur = 1'b0;
      TX_DATA:   tx_cur = tx_sh_q[0];
      TX_PARITY: tx_cur = tx_par_q;
      default:   tx_cur = 1'b1;
    endcase
    if (os_tick) tx_out_d = tx_cur;

    if (tx_state_q == TX_IDLE) begin
      if (tx_valid) begin
        tx_state_d = TX_START;
        tx_tcnt_d  = '0;
        tx_bit_d   = '0;
        tx_sh_d    = tx_data;
        tx_par_d   = parity_bit(9'(tx_data), PARITY_MODE);
      end
    end else if (os_tick) begin
      tx_tcnt_d = tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
          end
          TX_DATA: begin
            tx_sh_d = tx_sh_q >> 1;
            if (tx_bit_q == LAST_DATA) begin
              tx_state_d = (PARITY_MODE != PAR_NONE) ? TX_PARITY : TX_STOP;
              tx_bit_d   = '0;
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
            end
          end
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
          end
          TX_STOP: begin
            if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
            else                       tx_bit_d   = tx_bit_q + 4'd1;
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign tx_out   = tx_out_q;

  rx_state_e         rx_state_q, rx_state_d;
  logic [1:0]        rx_sync_q;
  logic [3:0]        rx_tcnt_q, rx_tcnt_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_wait_q, rx_wait_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_sel, rx_s;

  assign rx_sel = loopback ? tx_out_q : rx_in;
  assign rx_s   = rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_par_d   = rx_par_q;
    rx_wait_d  = rx_wait_q;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    rx_valid_d = 1'b0;

    if (os_tick) begin
      rx_tcnt_d = rx_tcnt_q + 4'd1;
      case (rx_state_q)
        RX_IDLE: begin
          // After a framing error the line must go high before a new start is trusted.
          if (rx_wait_q) begin
            if (rx_s) rx_wait_d = 1'b0;
          end else if (!rx_s) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = '0;
          end
        end
        RX_START: begin
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tcnt_q == 4'd15) begin
            rx_sh_d = {rx_s, rx_sh_q[DATA_W-1:1]};
            if (rx_bit_q == LAST_DATA)
              rx_state_d = (PARITY_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              rx_bit_d = rx_bit_q + 4'd1;
          end
        end
        RX_PARITY: begin
          if (rx_tcnt_q == 4'd15) begin
            rx_par_d   = rx_s;
            rx_state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tcnt_q == 4'd15) begin
            rx_data_d  = rx_sh_q;
            perr_d     = (PARITY_MODE != PAR_NONE) &&
                         (parity_bit(9'(rx_sh_q), PARITY_MODE) != rx_par_q);
            serr_d     = ~rx_s;
            rx_wait_d  = ~rx_s;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      rx_wait_q  <= 1'b0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_sel};
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      rx_wait_q  <= rx_wait_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_error = perr_q;
  assign stop_error   = serr_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at default parameters (8E1, 16 clocks per bit).
// Frames are driven or observed at negedge; received words are logged by a monitor.
module tb_uart_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, tx_out;
  logic       rx_in = 1'b1;
  logic       loopback = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, stop_error;

  int checks = 0;
  int passed = 0;

  int         rx_total = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_core #(
    .DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(16)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_out(tx_out),
    .rx_in(rx_in), .loopback(loopback), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_error(parity_error), .stop_error(stop_error)
  );

  always @(posedge clk) begin
    #1;
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rx_total = rx_total + 1;
      $display("rx word %h parity_error %b stop_error %b", rx_data, parity_error, stop_error);
    end
  end

  // Frame vector bit 0 = start bit, driven LSB first, 16 clocks per bit.
  task automatic drive_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      rx_in = f[i];
      repeat (16) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b need 1", tx_out); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b need 1", tx_ready); else passed++;
    checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b need 0", tx_busy); else passed++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b need 0", rx_valid); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h need 00", rx_data); else passed++;
    checks++; if (parity_error !== 1'b0) $display("FAIL reset_parity_error: got %b need 0", parity_error); else passed++;
    checks++; if (stop_error !== 1'b0) $display("FAIL reset_stop_error: got %b need 0", stop_error); else passed++;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback_a5();
    bit exp_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int base;
    int first_c;
    base = rx_total;
    first_c = -1;
    loopback = 1'b1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    $display("tx word a5 accepted");
    checks++; if (tx_ready !== 1'b0) $display("FAIL lb_ready_after_accept: got %b need 0", tx_ready); else passed++;
    checks++; if (tx_busy !== 1'b1) $display("FAIL lb_busy_after_accept: got %b need 1", tx_busy); else passed++;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c >= 8 && c <= 168 && ((c - 8) % 16) == 0) begin
        checks++;
        if (tx_out !== exp_bits[(c - 8) / 16])
          $display("FAIL lb_tx_bit%0d: got %b need %b", (c - 8) / 16, tx_out, exp_bits[(c - 8) / 16]);
        else passed++;
      end
      if (c == 100) begin
        checks++; if (tx_ready !== 1'b0) $display("FAIL lb_ready_midframe: got %b need 0", tx_ready); else passed++;
      end
      if (first_c < 0 && rx_total != base) first_c = c;
    end
    checks++; if (rx_total - base !== 1) $display("FAIL lb_rx_count: got %0d need 1", rx_total - base); else passed++;
    checks++; if (first_c < 165 || first_c > 180) $display("FAIL lb_rx_latency: got %0d need 165..180", first_c); else passed++;
    checks++; if (rx_data !== 8'hA5) $display("FAIL lb_rx_data: got %h need a5", rx_data); else passed++;
    checks++; if (parity_error !== 1'b0) $display("FAIL lb_parity_error: got %b need 0", parity_error); else passed++;
    checks++; if (stop_error !== 1'b0) $display("FAIL lb_stop_error: got %b need 0", stop_error); else passed++;
    checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL lb_tx_idle_after: got ready %b busy %b need 1 0", tx_ready, tx_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int base;
    int accepts;
    int ready_viol;
    base = rx_total;
    accepts = 0;
    ready_viol = 0;
    loopback = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int c = 0; c < 420; c++) begin
      if (accepts == 1 && c > 1 && c < 170 && tx_ready !== 1'b0) ready_viol++;
      if (tx_valid && tx_ready) begin
        accepts++;
        $display("tx word %h accepted", tx_data);
        @(negedge clk);
        if (accepts == 1) tx_data = 8'hFF;
        else tx_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    checks++; if (accepts !== 2) $display("FAIL b2b_accepts: got %0d need 2", accepts); else passed++;
    checks++; if (ready_viol !== 0) $display("FAIL b2b_ready_low: got %0d high cycles need 0", ready_viol); else passed++;
    checks++; if (rx_total - base !== 2) $display("FAIL b2b_rx_count: got %0d need 2", rx_total - base); else passed++;
    if (rx_total - base >= 2) begin
      checks++; if (rx_q[base] !== 8'h00) $display("FAIL b2b_word0: got %h need 00", rx_q[base]); else passed++;
      checks++; if (rx_q[base+1] !== 8'hFF) $display("FAIL b2b_word1: got %h need ff", rx_q[base+1]); else passed++;
    end
    checks++; if (parity_error !== 1'b0 || stop_error !== 1'b0)
      $display("FAIL b2b_flags: got %b %b need 0 0", parity_error, stop_error); else passed++;
  endtask

  task automatic test_parity_error();
    int base;
    base = rx_total;
    loopback = 1'b0;
    drive_frame({1'b1, 1'b1, 8'h3C, 1'b0});
    repeat (20) @(negedge clk);
    checks++; if (rx_total - base !== 1) $display("FAIL par_rx_count: got %0d need 1", rx_total - base); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL par_rx_data: got %h need 3c", rx_data); else passed++;
    checks++; if (parity_error !== 1'b1) $display("FAIL par_parity_error: got %b need 1", parity_error); else passed++;
    checks++; if (stop_error !== 1'b0) $display("FAIL par_stop_error: got %b need 0", stop_error); else passed++;
  endtask

  task automatic test_glitch();
    int base;
    base = rx_total;
    loopback = 1'b0;
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (80) @(negedge clk);
    checks++; if (rx_total - base !== 0) $display("FAIL glitch_rx_count: got %0d need 0", rx_total - base); else passed++;
    checks++; if (rx_data !== 8'h3C) $display("FAIL glitch_rx_data: got %h need 3c", rx_data); else passed++;
    checks++; if (parity_error !== 1'b1 || stop_error !== 1'b0)
      $display("FAIL glitch_flags: got %b %b need 1 0", parity_error, stop_error); else passed++;
  endtask

  task automatic test_stop_error();
    int base;
    base = rx_total;
    loopback = 1'b0;
    drive_frame({1'b0, 1'b0, 8'h81, 1'b0});
    repeat (32) @(negedge clk);
    checks++; if (rx_total - base !== 1) $display("FAIL stop_rx_count: got %0d need 1", rx_total - base); else passed++;
    checks++; if (rx_data !== 8'h81) $display("FAIL stop_rx_data: got %h need 81", rx_data); else passed++;
    checks++; if (stop_error !== 1'b1) $display("FAIL stop_stop_error: got %b need 1", stop_error); else passed++;
    checks++; if (parity_error !== 1'b0) $display("FAIL stop_parity_error: got %b need 0", parity_error); else passed++;
    base = rx_total;
    drive_frame({1'b1, 1'b0, 8'h42, 1'b0});
    repeat (20) @(negedge clk);
    checks++; if (rx_total - base !== 1) $display("FAIL recover_rx_count: got %0d need 1", rx_total - base); else passed++;
    checks++; if (rx_data !== 8'h42) $display("FAIL recover_rx_data: got %h need 42", rx_data); else passed++;
    checks++; if (stop_error !== 1'b0 || parity_error !== 1'b0)
      $display("FAIL recover_flags: got %b %b need 0 0", parity_error, stop_error); else passed++;
  endtask

  task automatic test_reset_midframe();
    int base;
    base = rx_total;
    loopback = 1'b1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    $display("tx word c3 accepted");
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_out !== 1'b1) $display("FAIL midrst_tx_out: got %b need 1", tx_out); else passed++;
    checks++; if (tx_ready !== 1'b1) $display("FAIL midrst_tx_ready: got %b need 1", tx_ready); else passed++;
    rst = 1'b1;
    repeat (250) @(negedge clk);
    checks++; if (rx_total - base !== 0) $display("FAIL midrst_no_rx: got %0d need 0", rx_total - base); else passed++;
    base = rx_total;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    $display("tx word 5a accepted");
    repeat (200) @(negedge clk);
    checks++; if (rx_total - base !== 1) $display("FAIL midrst_rx_count: got %0d need 1", rx_total - base); else passed++;
    checks++; if (rx_data !== 8'h5A) $display("FAIL midrst_rx_data: got %h need 5a", rx_data); else passed++;
    checks++; if (parity_error !== 1'b0 || stop_error !== 1'b0)
      $display("FAIL midrst_flags: got %b %b need 0 0", parity_error, stop_error); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_loopback_a5();
    repeat (20) @(negedge clk);
    test_back_to_back();
    repeat (20) @(negedge clk);
    test_parity_error();
    test_glitch();
    test_stop_error();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
